// File: rtl/branch_redirect_unit.sv
// PC generator and taken-branch redirect for the 5-stage pipeline.
// Predict-not-taken; a taken branch reloads the PC and squashes IF/ID, ID/EX.
module branch_redirect_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             to_branch,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc_out,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redirect_busy,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nx;
  logic [PC_W-1:0]  pc_nx;
  logic             flush_nx;
  logic             mis_nx;
  logic [CNT_W-1:0] cnt_nx;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nx = RUN;
    pc_nx    = pc_out + PC_STEP;
    flush_nx = 1'b0;
    mis_nx   = misalign_err;
    cnt_nx   = taken_count;
    unique case (state)
      RUN: begin
        if (to_branch) begin
          state_nx = FLUSH;
          pc_nx    = {branch_target[PC_W-1:2], 2'b00};
          flush_nx = 1'b1;
          mis_nx   = misalign_err | (|branch_target[1:0]);
          if (taken_count != CNT_MAX) begin
            cnt_nx = taken_count + CNT_W'(1);
          end
        end else if (stall) begin
          pc_nx = pc_out;
        end
      end
      FLUSH: begin
        state_nx = RUN;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out       <= RESET_PC;
      flush_ifid   <= 1'b0;
      flush_idex   <= 1'b0;
      misalign_err <= 1'b0;
      taken_count  <= '0;
    end else begin
      pc_out       <= pc_nx;
      flush_ifid   <= flush_nx;
      flush_idex   <= flush_nx;
      misalign_err <= mis_nx;
      taken_count  <= cnt_nx;
    end
  end

  assign redirect_busy = (state == FLUSH);

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit.
// Expected outputs queued at drive time, popped after each rising edge.
module tb_branch_redirect_unit;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             to_branch;
  logic [63:0]      branch_target;
  logic [63:0]      pc_out;
  logic             flush_ifid;
  logic             flush_idex;
  logic             redirect_busy;
  logic             misalign_err;
  logic [CNT_W-1:0] taken_count;

  branch_redirect_unit #(
    .PC_W    (64),
    .RESET_PC(64'h0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .to_branch    (to_branch),
    .branch_target(branch_target),
    .pc_out       (pc_out),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .redirect_busy(redirect_busy),
    .misalign_err (misalign_err),
    .taken_count  (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      pc;
    logic             fl;
    logic             mis;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0]      m_pc;
  logic             m_busy;
  logic             m_mis;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 64'h0;
    m_busy = 1'b0;
    m_mis  = 1'b0;
    m_cnt  = '0;
  endtask

  task automatic step(input logic st, input logic br,
                      input logic [63:0] tgt);
    exp_t e;
    stall         = st;
    to_branch     = br;
    branch_target = tgt;
    if (!m_busy && br) begin
      m_pc   = tgt & ~64'h3;
      m_busy = 1'b1;
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else if (!m_busy && st) begin
      m_busy = 1'b0;
    end else begin
      m_pc   = m_pc + 64'd4;
      m_busy = 1'b0;
    end
    e.pc  = m_pc;
    e.fl  = m_busy;
    e.mis = m_mis;
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      chk("pc_out", pc_out, e.pc);
      chk("flush_ifid", 64'(flush_ifid), 64'(e.fl));
      chk("flush_idex", 64'(flush_idex), 64'(e.fl));
      chk("redirect_busy", 64'(redirect_busy), 64'(e.fl));
      chk("misalign_err", 64'(misalign_err), 64'(e.mis));
      chk("taken_count", 64'(taken_count), 64'(e.cnt));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc_out, 64'h0);
    chk({tag, "_fi"}, 64'(flush_ifid), 64'h0);
    chk({tag, "_fe"}, 64'(flush_idex), 64'h0);
    chk({tag, "_busy"}, 64'(redirect_busy), 64'h0);
    chk({tag, "_mis"}, 64'(misalign_err), 64'h0);
    chk({tag, "_cnt"}, 64'(taken_count), 64'h0);
  endtask

  initial begin
    stall         = 1'b0;
    to_branch     = 1'b0;
    branch_target = 64'h0;
    rst_n         = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // sequential fetch
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'h0);
    chk("seq_pc10", pc_out, 64'h10);

    // basic taken branch
    step(1'b0, 1'b1, 64'h100);
    chk("br_pc", pc_out, 64'h100);
    chk("br_fl", 64'(flush_ifid & flush_idex & redirect_busy), 64'h1);
    step(1'b0, 1'b0, 64'h0);
    chk("br_pc4", pc_out, 64'h104);
    chk("br_cnt", 64'(taken_count), 64'h1);

    // stall holds PC at 0x20
    step(1'b0, 1'b1, 64'h1C);
    step(1'b0, 1'b0, 64'h0);
    chk("pre_stall", pc_out, 64'h20);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'h0);
    chk("stall_hold", pc_out, 64'h20);
    step(1'b0, 1'b0, 64'h0);
    chk("stall_rel", pc_out, 64'h24);

    // branch beats stall
    step(1'b1, 1'b1, 64'h80);
    chk("br_stall_pc", pc_out, 64'h80);
    chk("br_stall_fl", 64'(flush_ifid), 64'h1);
    step(1'b0, 1'b0, 64'h0);

    // branch during FLUSH dropped
    step(1'b0, 1'b1, 64'h200);
    step(1'b0, 1'b1, 64'h300);
    chk("b2b_drop", pc_out, 64'h204);
    step(1'b0, 1'b1, 64'h300);
    chk("b2b_take", pc_out, 64'h300);
    step(1'b0, 1'b0, 64'h0);

    // misaligned target, flag sticky
    step(1'b0, 1'b1, 64'h102);
    chk("mis_pc", pc_out, 64'h100);
    chk("mis_set", 64'(misalign_err), 64'h1);
    step(1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 64'h400);
    step(1'b0, 1'b0, 64'h0);
    chk("mis_sticky", 64'(misalign_err), 64'h1);

    // PC wrap at top of address space
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b0, 1'b0, 64'h0);
    chk("wrap_top", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 64'h0);
    chk("wrap_zero", pc_out, 64'h0);

    // random mix
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 3) == 0),
           {$urandom, $urandom});
    end

    // counter saturation
    for (int i = 0; i < 270; i++) begin
      step(1'b0, 1'b1, 64'h1000);
      step(1'b0, 1'b0, 64'h0);
    end
    chk("cnt_sat", 64'(taken_count), 64'hFF);

    // async reset during FLUSH
    step(1'b0, 1'b1, 64'h500);
    chk("pre_rst_busy", 64'(redirect_busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 64'h0);
    chk("post_rst_pc", pc_out, 64'h4);

    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
